tetris_input_ctrl: RTL
======================

TETRIS_INPUT_CTRL -- requirements
Module: tetris_input_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 20'd1_000_000; number of stable cycles required for a button level change to be accepted.
REQ-002 Parameter GRAVITY_CYCLES, default 27'd50_000_000; period between automatic DOWN commands.
REQ-003 Parameter GARBAGE_CYCLES, default 32'd500_000_000; period between BAR commands (GARBAGE_EN only).
REQ-004 Parameter FIFO_DEPTH, default 4; command queue depth, power of two.
REQ-005 clk  input  1  clock; reset reset_n, synchronous, active-low.
REQ-006 reset_n  input  1  synchronous active-low reset.
REQ-007 btn  input  6  raw asynchronous buttons: [0] LEFT, [1] RIGHT, [2] ROTATE, [3] ROTATE_REV, [4] DROP, [5] HOLD.
REQ-008 state  input  state_type  current game engine state.
REQ-009 ctrl  output  state_type  command presented to game engine; NONE when queue is empty.
REQ-010 bar_mask  output  10  garbage row for the head BAR entry, else 0.

Function
REQ-011 Each btn bit SHALL pass a 2-FF synchronizer, then a debouncer that accepts a new level only after DEBOUNCE_CYCLES consecutive identical synchronized samples.
REQ-012 A debounced 0->1 edge SHALL set that button's pending flag on the next clock; repeated edges while pending coalesce.
REQ-013 Gravity counter SHALL run only while state is not INIT or END, is held at 0 otherwise, and sets the DOWN pending flag when it reaches GRAVITY_CYCLES-1, then wraps to 0.
REQ-014 Arbiter SHALL enqueue at most one command per cycle, priority DOWN, BAR, then btn index 0..5 ascending, clearing the chosen flag on the enqueue edge.
REQ-015 When the FIFO is full the arbiter SHALL stall; pending flags persist, nothing is dropped except coalesced repeats.
REQ-016 ctrl SHALL equal the FIFO head whenever the FIFO is non-empty, with no extra register stage.
REQ-017 Pop SHALL occur on any edge where FIFO is non-empty and state is INIT, WAIT or END; at all other states the head is held unchanged.
REQ-018 Simultaneous pop and enqueue SHALL both take effect; count is unchanged; an enqueue into a full FIFO with simultaneous pop is permitted.
REQ-019 Latency: debounced edge at cycle t -> flag at t+1 -> ctrl valid at t+2 if FIFO empty and no higher-priority flag.
REQ-020 Pointers SHALL wrap modulo FIFO_DEPTH; count SHALL be log2(FIFO_DEPTH)+1 bits.

Reset
REQ-021 On reset_n low at a clock edge: FIFO empty, ctrl=NONE, bar_mask=0, all pending flags, debouncers, gravity and garbage counters 0, LFSR seed 16'hACE1.
REQ-022 Reset mid-operation SHALL discard queued and pending commands within the same edge.

Configuration
REQ-023 Macro TETRIS_GARBAGE_EN defined: 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every cycle; garbage counter runs like gravity; on wrap sets BAR pending; entry stores bar_mask = 10'h3FF with bit (lfsr mod 10) cleared, captured at enqueue.
REQ-024 Macro undefined: no LFSR, garbage counter, or mask storage; bar_mask tied to 0; BAR never issued.

Structure
REQ-025 state_type and button index constants SHALL live in the shared enum_type package; no new typedefs local to the module.
REQ-026 Debouncer SHALL be a sub-module btn_debounce (one instance per button, parameter DEBOUNCE_CYCLES); FIFO stays inline.

Verification
REQ-027 DEBOUNCE_CYCLES=4, btn[0] bounces 1-0-1 at 1-cycle spacing then stable high 10 cycles, state=WAIT -> exactly one LEFT on ctrl for one cycle, then NONE.
REQ-028 state=GEN held, press LEFT, RIGHT, DROP, HOLD, ROTATE -> FIFO fills with 4 entries in press order, ROTATE stays pending; state=WAIT -> five commands drain in order, one per cycle.
REQ-029 GRAVITY_CYCLES=8, state=WAIT, no buttons -> DOWN on ctrl every 8 cycles; state=END -> no DOWN generated.
REQ-030 DOWN and btn[1] flags set same cycle -> DOWN enqueued first, RIGHT next cycle.
REQ-031 TETRIS_GARBAGE_EN, GARBAGE_CYCLES=16 -> BAR with bar_mask having exactly nine ones; bar_mask=0 when head is not BAR; without macro bar_mask stays 0.
REQ-032 reset_n low for one cycle with 3 queued entries -> ctrl=NONE next cycle and no stale command reappears.

Source files
------------

// File: rtl/tetris_input_ctrl_pkg.sv
// Shared enum_type package: game engine state / command encoding and button indices.
// NONE is encoded as zero so an idle command bus reads as all-zero.
package enum_type;

  typedef enum logic [3:0] {
    NONE       = 4'd0,
    INIT       = 4'd1,
    GEN        = 4'd2,
    WAIT       = 4'd3,
    END        = 4'd4,
    DOWN       = 4'd5,
    BAR        = 4'd6,
    LEFT       = 4'd7,
    RIGHT      = 4'd8,
    ROTATE     = 4'd9,
    ROTATE_REV = 4'd10,
    DROP       = 4'd11,
    HOLD       = 4'd12
  } state_type;

  localparam int NUM_BTNS       = 6;
  localparam int BTN_LEFT       = 0;
  localparam int BTN_RIGHT      = 1;
  localparam int BTN_ROTATE     = 2;
  localparam int BTN_ROTATE_REV = 3;
  localparam int BTN_DROP       = 4;
  localparam int BTN_HOLD       = 5;

  function automatic state_type btn_cmd(input logic [2:0] idx);
    case (idx)
      3'd0:    return LEFT;
      3'd1:    return RIGHT;
      3'd2:    return ROTATE;
      3'd3:    return ROTATE_REV;
      3'd4:    return DROP;
      3'd5:    return HOLD;
      default: return NONE;
    endcase
  endfunction

endpackage

// File: rtl/tetris_input_ctrl_btn_debounce.sv
// btn_debounce: 2-FF synchronizer followed by a level debouncer; the output only
// follows the input after DEBOUNCE_CYCLES consecutive identical synchronized samples.
module btn_debounce #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_btn,
  output logic o_level
);

  logic        r_sync1;
  logic        r_sync2;
  logic        r_level;
  logic [19:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      if (r_sync2 != r_level) begin
        if (r_cnt == DEBOUNCE_CYCLES - 20'd1) begin
          r_level <= r_sync2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 20'd1;
        end
      end else begin
        // any sample matching the accepted level restarts the stability window
        r_cnt <= '0;
      end
    end
  end

  assign o_level = r_level;

endmodule

// File: rtl/tetris_input_ctrl.sv
// tetris_input_ctrl: debounced buttons + gravity (+ optional garbage rows) arbitrated into a
// small command FIFO whose head drives ctrl. Garbage feature enabled by macro TETRIS_GARBAGE_EN.
module tetris_input_ctrl
  import enum_type::*;
#(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1_000_000,
  parameter logic [26:0] GRAVITY_CYCLES  = 27'd50_000_000,
  parameter logic [31:0] GARBAGE_CYCLES  = 32'd500_000_000,
  parameter int          FIFO_DEPTH      = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] btn,
  input  state_type  state,
  output state_type  ctrl,
  output logic [9:0] bar_mask
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [NUM_BTNS-1:0] w_level;
  logic [NUM_BTNS-1:0] r_level_d;
  logic [NUM_BTNS-1:0] w_rise;
  logic [NUM_BTNS-1:0] r_pend_btn;
  logic [NUM_BTNS-1:0] w_clr_btn;
  logic                r_pend_down;
  logic                w_pend_bar;
  logic [26:0]         r_grav;
  logic                w_run;
  logic                w_grav_tc;
  logic [2:0]          w_btn_idx;
  state_type           w_cmd;
  logic                w_push;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [CNT_W-1:0]    r_count;
  state_type           r_fifo [FIFO_DEPTH];

  for (genvar g = 0; g < NUM_BTNS; g++) begin : g_db
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
      .clk    (clk),
      .reset_n(reset_n),
      .i_btn  (btn[g]),
      .o_level(w_level[g])
    );
  end

  assign w_rise    = w_level & ~r_level_d;
  assign w_run     = (state != INIT) && (state != END);
  assign w_grav_tc = w_run && (r_grav == GRAVITY_CYCLES - 27'd1);
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_pop     = !w_empty && ((state == INIT) || (state == WAIT) || (state == END));

  // fixed priority: DOWN, BAR, then lowest button index
  always_comb begin
    w_btn_idx = '0;
    for (int i = NUM_BTNS - 1; i >= 0; i--) begin
      if (r_pend_btn[i]) w_btn_idx = 3'(i);
    end
    w_cmd = NONE;
    if (r_pend_down)     w_cmd = DOWN;
    else if (w_pend_bar) w_cmd = BAR;
    else if (|r_pend_btn) w_cmd = btn_cmd(w_btn_idx);
  end

  assign w_push    = (w_cmd != NONE) && (!w_full || w_pop);
  assign w_clr_btn = (w_push && !r_pend_down && !w_pend_bar) ?
                     (NUM_BTNS'(1) << w_btn_idx) : '0;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_level_d   <= '0;
      r_pend_btn  <= '0;
      r_pend_down <= 1'b0;
      r_grav      <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
    end else begin
      r_level_d <= w_level;
      if (!w_run || w_grav_tc) r_grav <= '0;
      else                     r_grav <= r_grav + 27'd1;
      // a fresh edge on the same cycle as the enqueue is a new press, so set wins
      r_pend_down <= (r_pend_down & ~(w_push && (w_cmd == DOWN))) | w_grav_tc;
      r_pend_btn  <= (r_pend_btn & ~w_clr_btn) | w_rise;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= w_cmd;
  end

  assign ctrl = w_empty ? NONE : r_fifo[r_rd_ptr];

`ifdef TETRIS_GARBAGE_EN
  logic [15:0] r_lfsr;
  logic [31:0] r_garb;
  logic        r_pend_bar;
  logic [9:0]  r_mask [FIFO_DEPTH];
  logic        w_lfsr_fb;
  logic [3:0]  w_lfsr_mod;
  logic [9:0]  w_new_mask;
  logic        w_garb_tc;

  assign w_lfsr_fb  = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_lfsr_mod = 4'(r_lfsr % 16'd10);
  assign w_new_mask = 10'h3FF & ~(10'd1 << w_lfsr_mod);
  assign w_garb_tc  = w_run && (r_garb == GARBAGE_CYCLES - 32'd1);
  assign w_pend_bar = r_pend_bar;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_lfsr     <= 16'hACE1;
      r_garb     <= '0;
      r_pend_bar <= 1'b0;
    end else begin
      r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
      if (!w_run || w_garb_tc) r_garb <= '0;
      else                     r_garb <= r_garb + 32'd1;
      r_pend_bar <= (r_pend_bar & ~(w_push && (w_cmd == BAR))) | w_garb_tc;
    end
  end

  // the hole position is frozen when the BAR entry is written, not when it is popped
  always_ff @(posedge clk) begin
    if (w_push) r_mask[r_wr_ptr] <= w_new_mask;
  end

  assign bar_mask = (!w_empty && (ctrl == BAR)) ? r_mask[r_rd_ptr] : '0;
`else
  logic w_unused_garbage;

  assign w_unused_garbage = ^GARBAGE_CYCLES;
  assign w_pend_bar       = 1'b0;
  assign bar_mask         = '0;
`endif

endmodule
